// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one memory port between instruction fetch and the data
//             load/store path. Data has priority, a starvation counter
//             guarantees fetch progress, and a flush drops an in-flight
//             fetch response.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_req_i,
    // instruction fetch requester
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    // data requester
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic [3:0]      d_wmask_i,
    input  logic [XLEN-1:0] d_wdata_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [XLEN-1:0] d_rdata_o,
    // memory port
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_wmask_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            busy_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic c_own_if = 1'b0;
    localparam logic c_own_d  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              drop_q, drop_d;

    logic              resp_fire;
    logic              arb_pt;
    logic              if_eff;
    logic              pick_if;
    logic              pick_d;

    // Arbitration decode: flush hides a fetch request for the cycle it is seen
    always_comb begin
        resp_fire = (state_q == S_RESP) && mem_rvalid_i;
        arb_pt    = (state_q == S_IDLE) || resp_fire;
        if_eff    = if_req_i && !flush_req_i;
        pick_if   = if_eff && (!d_req_i || (starve_q == c_starve_max));
        pick_d    = d_req_i && !pick_if;
    end

    // Next-state, request capture, starvation count and drop flag
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        starve_d = starve_q;
        drop_d   = drop_q;

        if ((state_q == S_REQ) && mem_gnt_i) begin
            state_d = S_RESP;
        end

        if (arb_pt) begin
            if (pick_if) begin
                state_d  = S_REQ;
                owner_d  = c_own_if;
                we_d     = 1'b0;
                addr_d   = if_addr_i;
                wdata_d  = '0;
                wmask_d  = '0;
                starve_d = '0;
            end else if (pick_d) begin
                state_d = S_REQ;
                owner_d = c_own_d;
                we_d    = d_we_i;
                addr_d  = d_addr_i;
                wdata_d = d_wdata_i;
                wmask_d = d_wmask_i;
                if (!if_eff) begin
                    starve_d = '0;
                end else if (starve_q != c_starve_max) begin
                    starve_d = starve_q + c_cnt_one;
                end
            end else begin
                // nobody requesting, so fetch is not waiting either
                state_d  = S_IDLE;
                starve_d = '0;
            end
        end

        // A flush while a fetch is outstanding marks its response for discard;
        // the flag belongs to that transaction only and clears on its response.
        if ((state_q != S_IDLE) && (owner_q == c_own_if) && flush_req_i) begin
            drop_d = 1'b1;
        end
        if (resp_fire) begin
            drop_d = 1'b0;
        end
    end

    // State and request registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            owner_q  <= c_own_if;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            starve_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
        end
    end

    // Bus drive, grant and response steering
    always_comb begin
        mem_req_o   = (state_q == S_REQ);
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_wmask_o = wmask_q;
        busy_o      = (state_q != S_IDLE);

        if_gnt_o    = mem_req_o && mem_gnt_i && (owner_q == c_own_if);
        d_gnt_o     = mem_req_o && mem_gnt_i && (owner_q == c_own_d);

        // a fetch response coinciding with a flush is discarded as well
        if_rvalid_o = resp_fire && (owner_q == c_own_if) && !drop_q && !flush_req_i;
        d_rvalid_o  = resp_fire && (owner_q == c_own_d);
        if_rdata_o  = mem_rdata_i;
        d_rdata_o   = mem_rdata_i;
    end

`ifndef SYNTHESIS
    // Memory may only respond while a transaction is outstanding
    a_rvalid_in_resp : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mem_rvalid_i && (state_q != S_RESP)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter: a cycle
//             table for basic traffic plus hand sequences for starvation,
//             flush, delayed grant and reset mid-transaction.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_req_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i, d_we_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic [3:0]  d_wmask_i;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_req_i(flush_req_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
        .d_wmask_i(d_wmask_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    typedef struct {
        logic        flush, if_req;
        logic [31:0] if_addr;
        logic        d_req, d_we;
        logic [31:0] d_addr;
        logic        gnt, rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_if_gnt, e_if_rv, e_d_gnt, e_d_rv, e_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic fl, input logic ir, input logic [31:0] ia,
        input logic dr, input logic dw, input logic [31:0] da,
        input logic g, input logic rv, input logic [31:0] rd,
        input logic er, input logic [31:0] ea,
        input logic eig, input logic eirv, input logic edg, input logic edrv,
        input logic eb);
        vec_t v;
        v.flush = fl; v.if_req = ir; v.if_addr = ia;
        v.d_req = dr; v.d_we = dw; v.d_addr = da;
        v.gnt = g; v.rvalid = rv; v.rdata = rd;
        v.e_req = er; v.e_addr = ea;
        v.e_if_gnt = eig; v.e_if_rv = eirv; v.e_d_gnt = edg; v.e_d_rv = edrv;
        v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush_req_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wmask_i = '0; d_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic chk_outs(input string tag, input logic er, input logic eig,
                            input logic eirv, input logic edg, input logic edrv,
                            input logic eb);
        chk({tag, ".mem_req"},   {31'd0, mem_req_o},   {31'd0, er});
        chk({tag, ".if_gnt"},    {31'd0, if_gnt_o},    {31'd0, eig});
        chk({tag, ".if_rvalid"}, {31'd0, if_rvalid_o}, {31'd0, eirv});
        chk({tag, ".d_gnt"},     {31'd0, d_gnt_o},     {31'd0, edg});
        chk({tag, ".d_rvalid"},  {31'd0, d_rvalid_o},  {31'd0, edrv});
        chk({tag, ".busy"},      {31'd0, busy_o},      {31'd0, eb});
    endtask

    vec_t tbl[12];
    int   d_gnt_count;

    initial begin
        // single fetch, zero-wait memory
        tbl[0]  = mk(0,1,32'h100, 0,0,0, 0,0,0,            0,0,      0,0,0,0,0);
        tbl[1]  = mk(0,1,32'h100, 0,0,0, 1,0,0,            1,32'h100,1,0,0,0,1);
        tbl[2]  = mk(0,0,0,       0,0,0, 0,1,32'hDEADBEEF, 0,0,      0,1,0,0,1);
        tbl[3]  = mk(0,0,0,       0,0,0, 0,0,0,            0,0,      0,0,0,0,0);
        // flush at an arbitration point hides the fetch request
        tbl[4]  = mk(1,1,32'h140, 0,0,0, 0,0,0,            0,0,      0,0,0,0,0);
        tbl[5]  = mk(0,0,0,       0,0,0, 0,0,0,            0,0,      0,0,0,0,0);
        // simultaneous requests: data first, fetch right after its response
        tbl[6]  = mk(0,1,32'h104, 1,0,32'h2000, 0,0,0,     0,0,      0,0,0,0,0);
        tbl[7]  = mk(0,1,32'h104, 1,0,32'h2000, 1,0,0,     1,32'h2000,0,0,1,0,1);
        tbl[8]  = mk(0,1,32'h104, 0,0,0, 0,1,32'h55,       0,0,      0,0,0,1,1);
        tbl[9]  = mk(0,1,32'h104, 0,0,0, 1,0,0,            1,32'h104,1,0,0,0,1);
        tbl[10] = mk(0,0,0,       0,0,0, 0,1,32'h77,       0,0,      0,1,0,0,1);
        tbl[11] = mk(0,0,0,       0,0,0, 0,0,0,            0,0,      0,0,0,0,0);

        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk_outs("reset", 0,0,0,0,0,0);
        chk("reset.mem_addr", mem_addr_o, 32'h0);
        chk("reset.mem_we", {31'd0, mem_we_o}, 32'h0);
        rst_ni = 1'b1;

        // ---------------- table-driven cycles ----------------
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            flush_req_i = tbl[i].flush;
            if_req_i = tbl[i].if_req; if_addr_i = tbl[i].if_addr;
            d_req_i = tbl[i].d_req; d_we_i = tbl[i].d_we; d_addr_i = tbl[i].d_addr;
            mem_gnt_i = tbl[i].gnt; mem_rvalid_i = tbl[i].rvalid; mem_rdata_i = tbl[i].rdata;
            #1;
            chk_outs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_if_gnt,
                     tbl[i].e_if_rv, tbl[i].e_d_gnt, tbl[i].e_d_rv, tbl[i].e_busy);
            if (tbl[i].e_req)
                chk($sformatf("vec%0d.mem_addr", i), mem_addr_o, tbl[i].e_addr);
            if (tbl[i].e_if_rv)
                chk($sformatf("vec%0d.if_rdata", i), if_rdata_o, tbl[i].rdata);
        end

        // ---------------- starvation: 4 data, then fetch, then data ----------------
        @(negedge clk_i);
        idle_inputs();
        if_req_i = 1'b1; if_addr_i = 32'h300;
        d_req_i = 1'b1; d_addr_i = 32'h2004;
        #1;
        chk("starve.idle_busy", {31'd0, busy_o}, 32'h0);
        for (int k = 0; k < 6; k++) begin
            logic exp_if;
            exp_if = (k == 4);
            @(negedge clk_i);
            mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
            #1;
            chk($sformatf("starve%0d.if_gnt", k), {31'd0, if_gnt_o}, {31'd0, exp_if});
            chk($sformatf("starve%0d.d_gnt", k),  {31'd0, d_gnt_o},  {31'd0, !exp_if});
            chk($sformatf("starve%0d.mem_addr", k), mem_addr_o, exp_if ? 32'h300 : 32'h2004);
            @(negedge clk_i);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1000 + k;
            if (k == 4) if_req_i = 1'b0;
            if (k == 5) d_req_i = 1'b0;
            #1;
            chk($sformatf("starve%0d.if_rvalid", k), {31'd0, if_rvalid_o}, {31'd0, exp_if});
            chk($sformatf("starve%0d.d_rvalid", k),  {31'd0, d_rvalid_o},  {31'd0, !exp_if});
        end
        @(negedge clk_i);
        idle_inputs();
        #1;
        chk("starve.end_busy", {31'd0, busy_o}, 32'h0);

        // ---------------- flush during fetch RESP, 3-cycle latency ----------------
        if_req_i = 1'b1; if_addr_i = 32'h180;
        @(negedge clk_i);
        mem_gnt_i = 1'b1;
        #1;
        chk("flush.if_gnt", {31'd0, if_gnt_o}, 32'h1);
        @(negedge clk_i);
        idle_inputs();
        flush_req_i = 1'b1;
        #1;
        chk_outs("flush.c2", 0,0,0,0,0,1);
        @(negedge clk_i);
        flush_req_i = 1'b0;
        #1;
        chk_outs("flush.c3", 0,0,0,0,0,1);
        @(negedge clk_i);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
        if_req_i = 1'b1; if_addr_i = 32'h200;
        #1;
        chk_outs("flush.dropped", 0,0,0,0,0,1);
        @(negedge clk_i);
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
        #1;
        chk_outs("flush.next_req", 1,1,0,0,0,1);
        chk("flush.next_addr", mem_addr_o, 32'h200);
        @(negedge clk_i);
        idle_inputs();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h600D600D;
        #1;
        chk_outs("flush.next_resp", 0,0,1,0,0,1);
        chk("flush.next_rdata", if_rdata_o, 32'h600D600D);

        // ---------------- store with grant delayed two cycles ----------------
        @(negedge clk_i);
        idle_inputs();
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h3000;
        d_wmask_i = 4'b0011; d_wdata_i = 32'h1234;
        d_gnt_count = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            mem_gnt_i = (c == 2);
            #1;
            if (d_gnt_o) d_gnt_count++;
            chk($sformatf("store%0d.mem_req", c), {31'd0, mem_req_o}, 32'h1);
            chk($sformatf("store%0d.mem_we", c), {31'd0, mem_we_o}, 32'h1);
            chk($sformatf("store%0d.mem_addr", c), mem_addr_o, 32'h3000);
            chk($sformatf("store%0d.mem_wmask", c), {28'd0, mem_wmask_o}, 32'h3);
            chk($sformatf("store%0d.mem_wdata", c), mem_wdata_o, 32'h1234);
        end
        @(negedge clk_i);
        idle_inputs();
        mem_rvalid_i = 1'b1;
        #1;
        if (d_gnt_o) d_gnt_count++;
        chk_outs("store.ack", 0,0,0,0,1,1);
        chk("store.gnt_count", d_gnt_count, 32'd1);

        // ---------------- reset while in RESP ----------------
        @(negedge clk_i);
        idle_inputs();
        if_req_i = 1'b1; if_addr_i = 32'h400;
        @(negedge clk_i);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        idle_inputs();
        #1;
        chk("rst.in_resp_busy", {31'd0, busy_o}, 32'h1);
        rst_ni = 1'b0;
        #1;
        chk_outs("rst.async", 0,0,0,0,0,0);
        chk("rst.mem_addr", mem_addr_o, 32'h0);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFEEDFACE;
        #1;
        chk_outs("rst.late_rvalid", 0,0,0,0,0,0);
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        rst_ni = 1'b1;
        #1;
        chk_outs("rst.after", 0,0,0,0,0,0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Hard stop in case the sequence above is ever blocked
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_err + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between instruction fetch (IF) and the data load/store path (MEM stage). It arbitrates, registers the winning request onto the memory bus, tracks the single outstanding transaction, and steers the response back to its owner. Data has priority; a starvation counter guarantees fetch progress. A pipeline flush cancels delivery of an in-flight fetch response.

## Interface
Parameters:
- XLEN, 32, address/data width
- STARVE_LIMIT, 4, consecutive data wins allowed while IF waits (≥1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous reset, active low
- flush_req_i  in  1  pipeline flush; drops the pending/in-flight fetch response
- if_req_i  in  1  fetch request; held with if_addr_i until if_gnt_o
- if_addr_i  in  XLEN  fetch address
- if_gnt_o  out  1  fetch request accepted by memory
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  XLEN  fetch data
- d_req_i  in  1  data request; held with all d_* until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  XLEN  data address
- d_wmask_i  in  4  byte write mask
- d_wdata_i  in  XLEN  store data
- d_gnt_o  out  1  data request accepted
- d_rvalid_o  out  1  load data / store ack valid
- d_rdata_o  out  XLEN  load data
- mem_req_o, mem_we_o  out  1 each  memory request, write enable
- mem_addr_o, mem_wdata_o  out  XLEN each
- mem_wmask_o  out  4
- mem_gnt_i  in  1  memory accepted request this cycle
- mem_rvalid_i  in  1  response (every granted transaction, incl. stores)
- mem_rdata_i  in  XLEN  response data
- busy_o  out  1  state != IDLE

## Operation
- FSM: IDLE, REQ (mem_req_o=1, waiting mem_gnt_i), RESP (waiting mem_rvalid_i). One outstanding transaction maximum.
- Arbitration point: IDLE, or RESP in the cycle mem_rvalid_i=1. Winner's request fields and owner (IF/D) are registered; next state REQ. No requester → IDLE.
- Priority: D wins if d_req_i, unless starve_cnt == STARVE_LIMIT and if_req_i, then IF wins.
- starve_cnt: +1 when D wins while if_req_i=1 (saturates at STARVE_LIMIT); cleared when IF wins or when if_req_i=0 at an arbitration point.
- REQ: mem_* driven from registers. On mem_gnt_i: owner's gnt_o=1 (combinational from mem_gnt_i, same cycle), go RESP.
- RESP: on mem_rvalid_i, owner's rvalid_o=1, rdata_o=mem_rdata_i (both rdata outputs pass mem_rdata_i; only rvalid gated). D rvalid for stores is an ack; rdata ignored.
- Flush: sets drop flag if owner==IF in REQ or RESP; REQ still completes on the bus (not withdrawn), if_gnt_o still asserted; the response is consumed with if_rvalid_o=0. Drop flag cleared at that response. flush_req_i=1 at an arbitration point masks if_req_i for that cycle (D may still win). Data transactions never affected by flush.
- mem_req_o=0 outside REQ; register contents otherwise don't-care.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, starve_cnt 0, drop 0, owner IF; all outputs 0 (mem_req_o, gnt, rvalid, busy_o, data/addr 0).
- Request latency: req_i seen in cycle N at arbitration point → mem_req_o=1 in N+1; gnt in first cycle with mem_gnt_i.
- Back-to-back: rvalid cycle also arbitrates → next mem_req_o the following cycle; peak one transaction per 2 cycles with zero-wait memory.
- mem_rvalid_i in IDLE/REQ is illegal; ignored (assertion in sim).
- mem_gnt_i outside REQ ignored.
- Reset mid-transaction: everything abandoned, no gnt/rvalid after reset.

## Test plan
- Single fetch, zero-wait memory: if_req_i=1 addr 0x100 at cycle 0 → mem_req_o/addr 0x100 cycle 1, if_gnt_o cycle 1, if_rvalid_o with mem data 0xDEADBEEF cycle 2.
- Simultaneous if_req_i and d_req_i (load 0x2000) → D granted first, IF issued immediately after D's rvalid cycle; starve_cnt=1.
- Continuous d_req_i with STARVE_LIMIT=4, IF waiting → exactly 4 D transactions, then 1 IF, then D again; no IF wait beyond 5 transactions.
- Flush during IF RESP with 3-cycle memory latency → mem response consumed, if_rvalid_o stays 0, next fetch 0x200 returns normally.
- Store 0x3000, wmask 0b0011, data 0x1234 with mem_gnt_i delayed 2 cycles → mem_* stable across wait, d_gnt_o once, d_rvalid_o on ack.
- rst_ni low while in RESP → all outputs 0 immediately, state IDLE; late mem_rvalid_i produces no rvalid.
